// File: rtl/cpu_types_pkg.sv
// Shared CPU datatypes: default datapath width and the multiply/divide opcode set.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mduop_t;

  function automatic logic mdu_is_div(input mduop_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_signed(input mduop_t op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-and-add multiply, or restoring divide on {rem, quot}.
module mdu_step #(
  parameter int WORD_W = 32
) (
  input  logic                  is_div,
  input  logic [2*WORD_W-1:0]   p_in,
  input  logic [2*WORD_W-1:0]   m_in,
  input  logic [WORD_W-1:0]     r_in,
  output logic [2*WORD_W-1:0]   p_out,
  output logic [2*WORD_W-1:0]   m_out,
  output logic [WORD_W-1:0]     r_out
);

  logic [WORD_W:0] rem_shift;
  logic [WORD_W:0] diff;
  logic            ge;

  always_comb begin
    // Remainder is always below the divisor, so one extra bit covers the shifted value.
    rem_shift = p_in[2*WORD_W-1:WORD_W-1];
    diff      = rem_shift - {1'b0, m_in[WORD_W-1:0]};
    ge        = ~diff[WORD_W];
    if (is_div) begin
      p_out = ge ? {diff[WORD_W-1:0], p_in[WORD_W-2:0], 1'b1}
                 : {rem_shift[WORD_W-1:0], p_in[WORD_W-2:0], 1'b0};
      m_out = m_in;
      r_out = r_in;
    end else begin
      p_out = r_in[0] ? (p_in + m_in) : p_in;
      m_out = m_in << 1;
      r_out = r_in >> 1;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply-divide unit, one bit per cycle, results sign-corrected on exit.
// Defining MDU_EARLY_OUT_EN lets multiplies finish once the remaining multiplier bits are zero.
module mult_div_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = cpu_types_pkg::WORD_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  mduop_t            mduop,
  input  logic [WORD_W-1:0] port_a,
  input  logic [WORD_W-1:0] port_b,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo,
  output logic              div_zero
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_W - 1);

  logic [1:0]          state_q, state_d;
  mduop_t              op_q, op_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic [2*WORD_W-1:0] p_q, p_d;
  logic [2*WORD_W-1:0] m_q, m_d;
  logic [WORD_W-1:0]   r_q, r_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   hi_q, hi_d;
  logic [WORD_W-1:0]   lo_q, lo_d;
  logic                dz_q, dz_d;

  logic [2*WORD_W-1:0] p_nxt, m_nxt;
  logic [WORD_W-1:0]   r_nxt;
  logic [WORD_W-1:0]   a_mag, b_mag;
  logic [2*WORD_W-1:0] prod_fix;
  logic [WORD_W-1:0]   quot_fix, rem_fix;
  logic                last_iter;

  mdu_step #(.WORD_W(WORD_W)) u_step (
    .is_div (mdu_is_div(op_q)),
    .p_in   (p_q),
    .m_in   (m_q),
    .r_in   (r_q),
    .p_out  (p_nxt),
    .m_out  (m_nxt),
    .r_out  (r_nxt)
  );

  assign a_mag = (mdu_is_signed(mduop) && port_a[WORD_W-1]) ? -port_a : port_a;
  assign b_mag = (mdu_is_signed(mduop) && port_b[WORD_W-1]) ? -port_b : port_b;

  assign prod_fix = neg_q  ? -p_nxt : p_nxt;
  assign quot_fix = neg_q  ? -p_nxt[WORD_W-1:0] : p_nxt[WORD_W-1:0];
  assign rem_fix  = rneg_q ? -p_nxt[2*WORD_W-1:WORD_W] : p_nxt[2*WORD_W-1:WORD_W];

`ifdef MDU_EARLY_OUT_EN
  assign last_iter = (cnt_q == CNT_MAX) || (!mdu_is_div(op_q) && (r_nxt == '0));
`else
  assign last_iter = (cnt_q == CNT_MAX);
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    p_d     = p_q;
    m_d     = m_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = mduop;
          neg_d  = mdu_is_signed(mduop) && (port_a[WORD_W-1] ^ port_b[WORD_W-1]);
          rneg_d = mdu_is_signed(mduop) && port_a[WORD_W-1];
          cnt_d  = '0;
          if (mdu_is_div(mduop)) begin
            p_d = {{WORD_W{1'b0}}, a_mag};
            m_d = {{WORD_W{1'b0}}, b_mag};
            r_d = '0;
          end else begin
            p_d = '0;
            m_d = {{WORD_W{1'b0}}, a_mag};
            r_d = b_mag;
          end
          // Divide by zero bypasses iteration and reports the raw dividend.
          if (mdu_is_div(mduop) && (port_b == '0)) begin
            state_d = ST_DONE;
            hi_d    = port_a;
            lo_d    = '1;
            dz_d    = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        p_d   = p_nxt;
        m_d   = m_nxt;
        r_d   = r_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = ST_DONE;
          dz_d    = 1'b0;
          if (mdu_is_div(op_q)) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[2*WORD_W-1:WORD_W];
            lo_d = prod_fix[WORD_W-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      op_q    <= MDU_MULT;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      p_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      p_q     <= p_d;
      m_q     <= m_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors queue expectations, a monitor checks each done.
module tb_mult_div_unit;
  import cpu_types_pkg::*;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  mduop_t      mduop = MDU_MULT;
  logic [31:0] port_a = '0;
  logic [31:0] port_b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  mult_div_unit #(.WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .mduop(mduop),
    .port_a(port_a), .port_b(port_b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  typedef struct {
    mduop_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          lat_eo;
  } vec_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pops one expectation.
  always @(posedge CLK) begin : monitor
    exp_t e;
    #1;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d required no done", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("div_zero", 64'(div_zero), 64'(e.dz));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (busy === 1'b0) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL idle_timeout: got busy=%b required 0 within 200 cycles", busy);
  endtask

  task automatic issue(input vec_t v);
    wait_idle();
    mduop  = v.op;
    port_a = v.a;
    port_b = v.b;
    start  = 1'b1;
    exp_q.push_back('{hi: v.hi, lo: v.lo, dz: v.dz, cyc: cyc + (EARLY ? v.lat_eo : v.lat)});
    @(negedge CLK);
    start  = 1'b0;
    port_a = ~v.a;
    port_b = ~v.b;
    mduop  = MDU_DIVU;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 33};
    vecs[1]  = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, 4};
    vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 33};
    vecs[3]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 33};
    vecs[4]  = '{MDU_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 1,  1};
    vecs[5]  = '{MDU_MULTU, 32'd5,        32'd3,        32'd0,        32'd15,       1'b0, 33, 3};
    vecs[6]  = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33, 33};
    vecs[7]  = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33, 33};
    vecs[8]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 33};
    vecs[9]  = '{MDU_DIV,   32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 1'b1, 1,  1};
    vecs[10] = '{MDU_MULT,  32'h00001234, 32'd0,        32'd0,        32'd0,        1'b0, 33, 2};
    vecs[11] = '{MDU_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        1'b0, 33, 33};

    repeat (3) @(negedge CLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    RST = 1'b0;

    foreach (vecs[i]) issue(vecs[i]);

    // Results hold after done until the next operation completes.
    wait_idle();
    repeat (5) @(negedge CLK);
    chk("hold_hi", 64'(hi), 64'hFFFFFFFE);
    chk("hold_lo", 64'(lo), 64'd2);
    chk("hold_div_zero", 64'(div_zero), 64'd0);

    // Start during busy, with different operands, must be ignored.
    issue('{MDU_MULT, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 33, 4});
    repeat (1) @(negedge CLK);
    mduop = MDU_DIVU; port_a = 32'd55; port_b = 32'd0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge CLK);
    chk("busy_start_ignored", 64'(busy), 64'd0);

    // Start presented only in the DONE cycle must be ignored.
    issue('{MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 33});
    begin : find_done
      for (int i = 0; i < 100; i++) begin
        if (done === 1'b1) disable find_done;
        @(negedge CLK);
      end
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done required done within 100 cycles");
    end
    mduop = MDU_DIVU; port_a = 32'd9; port_b = 32'd0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    chk("done_cycle_start_ignored", 64'(busy), 64'd0);

    // Reset mid-operation aborts it, clears results and beats a simultaneous start.
    issue('{MDU_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, 1, 1});
    wait_idle();
    mduop = MDU_MULT; port_a = 32'd9; port_b = 32'd9; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (10) @(negedge CLK);
    RST = 1'b1; start = 1'b1; mduop = MDU_MULTU;
    @(negedge CLK);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_div_zero", 64'(div_zero), 64'd0);
    RST = 1'b0; start = 1'b0;
    repeat (40) @(negedge CLK);
    chk("abort_no_restart", 64'(busy), 64'd0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge CLK);
    chk("pending_expectations", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
